// File: rtl/mfp_ahb_sevenseg_mux_pkg.sv
// Shared constants for the multiplexed 7-segment AHB slave: register
// offsets, AHB transfer type, and the hex-to-segment table.
package mfp_ahb_sevenseg_mux_pkg;

  // Register byte offsets within the slave
  localparam logic [3:0] H_SSM_DIGLO = 4'h0;
  localparam logic [3:0] H_SSM_DIGHI = 4'h4;
  localparam logic [3:0] H_SSM_CTRL  = 4'h8;
  localparam logic [3:0] H_SSM_CFG   = 4'hC;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  // Segment patterns ordered {CA,CB,CC,CD,CE,CF,CG}, 1 = segment lit
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  // Hex nibble to lit-segment pattern (active-high)
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/mfp_ahb_sevenseg_scan.sv
// Digit scanner: refresh, PWM and blink counters plus the registered
// pad-driving stage. All pad outputs are active-low.
module mfp_ahb_sevenseg_scan #(
  parameter int          NUM_DIGITS  = 8,
  parameter logic [15:0] REFRESH_DIV = 16'd50000,
  parameter logic [23:0] BLINK_DIV   = 24'd5000000
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [63:0]           nibbles,
  input  logic [15:0]           en,
  input  logic [15:0]           dp,
  input  logic [15:0]           blink,
  input  logic [3:0]            bright,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp_n
);
  import mfp_ahb_sevenseg_mux_pkg::*;

  localparam logic [3:0] SEL_LAST = 4'(NUM_DIGITS - 1);

  logic [15:0]           refresh_cnt_reg;
  logic [3:0]            sel_reg;
  logic [3:0]            pwm_reg;
  logic [23:0]           blink_cnt_reg;
  logic                  blink_phase_reg;
  logic [NUM_DIGITS-1:0] an_reg;
  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            seg_reg;
  logic                  dp_n_reg;
  logic                  digit_vis;
  logic [3:0]            cur_nib;

  // Refresh counter; advances the selected digit at each wrap
  always_ff @(posedge clk) begin
    if (srst) begin
      refresh_cnt_reg <= '0;
      sel_reg         <= '0;
    end else if (refresh_cnt_reg == REFRESH_DIV - 16'd1) begin
      refresh_cnt_reg <= '0;
      sel_reg         <= (sel_reg == SEL_LAST) ? 4'd0 : sel_reg + 4'd1;
    end else begin
      refresh_cnt_reg <= refresh_cnt_reg + 16'd1;
    end
  end

  // Free-running brightness PWM counter
  always_ff @(posedge clk) begin
    if (srst) pwm_reg <= '0;
    else      pwm_reg <= pwm_reg + 4'd1;
  end

  // Blink half-period counter; phase starts visible
  always_ff @(posedge clk) begin
    if (srst) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b1;
    end else if (blink_cnt_reg == BLINK_DIV - 24'd1) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= ~blink_phase_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + 24'd1;
    end
  end

  assign cur_nib   = nibbles[{sel_reg, 2'b00} +: 4];
  assign digit_vis = en[sel_reg] & (pwm_reg <= bright)
                   & ~(blink[sel_reg] & ~blink_phase_reg);

  // One anode per digit, low only for the visible selected digit
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
      assign an_next[gi] = ~(digit_vis && (sel_reg == 4'(gi)));
    end
  endgenerate

  // Registered pad stage; blanked digits park everything high
  always_ff @(posedge clk) begin
    if (srst) begin
      an_reg   <= '1;
      seg_reg  <= '1;
      dp_n_reg <= 1'b1;
    end else begin
      an_reg   <= an_next;
      seg_reg  <= digit_vis ? ~hex_to_seg(cur_nib) : 7'h7F;
      dp_n_reg <= digit_vis ? ~dp[sel_reg] : 1'b1;
    end
  end

  assign an   = an_reg;
  assign seg  = seg_reg;
  assign dp_n = dp_n_reg;

endmodule

// File: rtl/mfp_ahb_sevenseg_mux.sv
// AHB-Lite slave for a multiplexed common-anode 7-segment bank:
// address-phase capture, four registers, readback, and the scanner.
module mfp_ahb_sevenseg_mux #(
  parameter int          NUM_DIGITS  = 8,
  parameter logic [15:0] REFRESH_DIV = 16'd50000,
  parameter logic [23:0] BLINK_DIV   = 24'd5000000
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [3:0]            HADDR,
  input  logic [31:0]           HWDATA,
  output logic [31:0]           HRDATA,
  output logic                  CA,
  output logic                  CB,
  output logic                  CC,
  output logic                  CD,
  output logic                  CE,
  output logic                  CF,
  output logic                  CG,
  output logic                  DP,
  output logic [NUM_DIGITS-1:0] AN
);
  import mfp_ahb_sevenseg_mux_pkg::*;

  logic        hsel_reg;
  logic [1:0]  htrans_reg;
  logic        hwrite_reg;
  logic [3:0]  haddr_reg;
  logic        we;
  logic        re;
  logic [31:0] diglo_reg;
  logic [31:0] dighi_reg;
  logic [31:0] ctrl_reg;
  logic [19:0] cfg_reg;
  logic [6:0]  seg;

  // Capture the address phase for use in the following data phase
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hsel_reg   <= 1'b0;
      htrans_reg <= 2'b00;
      hwrite_reg <= 1'b0;
      haddr_reg  <= 4'h0;
    end else begin
      hsel_reg   <= HSEL;
      htrans_reg <= HTRANS;
      hwrite_reg <= HWRITE;
      haddr_reg  <= HADDR;
    end
  end

  assign we = hsel_reg &  hwrite_reg & (htrans_reg != HTRANS_IDLE);
  assign re = hsel_reg & ~hwrite_reg & (htrans_reg != HTRANS_IDLE);

  // Register file; writes land at the end of the data phase
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      diglo_reg <= 32'h0;
      dighi_reg <= 32'h0;
      ctrl_reg  <= 32'h0000_FFFF;
      cfg_reg   <= 20'hF_0000;
    end else if (we) begin
      case (haddr_reg)
        H_SSM_DIGLO: diglo_reg <= HWDATA;
        H_SSM_DIGHI: dighi_reg <= HWDATA;
        H_SSM_CTRL:  ctrl_reg  <= HWDATA;
        H_SSM_CFG:   cfg_reg   <= HWDATA[19:0];
        default: ;
      endcase
    end
  end

  // Combinational readback; zero when idle or unmapped
  always_comb begin
    HRDATA = 32'h0;
    if (re) begin
      case (haddr_reg)
        H_SSM_DIGLO: HRDATA = diglo_reg;
        H_SSM_DIGHI: HRDATA = dighi_reg;
        H_SSM_CTRL:  HRDATA = ctrl_reg;
        H_SSM_CFG:   HRDATA = {12'h0, cfg_reg};
        default:     HRDATA = 32'h0;
      endcase
    end
  end

  mfp_ahb_sevenseg_scan #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .BLINK_DIV  (BLINK_DIV)
  ) u_scan (
    .clk    (HCLK),
    .srst   (HRESET),
    .nibbles({dighi_reg, diglo_reg}),
    .en     (ctrl_reg[15:0]),
    .dp     (ctrl_reg[31:16]),
    .blink  (cfg_reg[15:0]),
    .bright (cfg_reg[19:16]),
    .an     (AN),
    .seg    (seg),
    .dp_n   (DP)
  );

  assign {CA, CB, CC, CD, CE, CF, CG} = seg;

endmodule

// File: tb/tb_mfp_ahb_sevenseg_mux.sv
// Directed bench for the 7-segment mux: 4 digits, 16-cycle slots,
// 64-cycle blink half-period.
module tb_mfp_ahb_sevenseg_mux;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [3:0]  HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        CA, CB, CC, CD, CE, CF, CG, DP;
  logic [3:0]  AN;

  int checks = 0;
  int errors = 0;
  int s = 0;

  logic [31:0] sh_diglo, sh_dighi, sh_ctrl, sh_cfg;
  logic [31:0] rd;

  mfp_ahb_sevenseg_mux #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(16'd16),
    .BLINK_DIV  (24'd64)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG),
    .DP(DP), .AN(AN)
  );

  always #5 HCLK = ~HCLK;

  // Edges since the last reset release
  always @(posedge HCLK) begin
    if (HRESET) s <= 0;
    else        s <= s + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Lit segments {a..g} for a hex digit
  function automatic logic [6:0] lit7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  // Expected {AN, CA..CG, DP} after S edges since release
  function automatic logic [11:0] expect_pads(input int S);
    int st, sel, pwm;
    bit bp, vis;
    logic [3:0] an;
    if (S == 0) return 12'hFFF;
    st  = S - 1;
    sel = (st / 16) % 4;
    pwm = st % 16;
    bp  = ((st / 64) % 2) == 0;
    vis = sh_ctrl[sel] && (pwm <= int'(sh_cfg[19:16])) && !(sh_cfg[sel] && !bp);
    if (!vis) return 12'hFFF;
    an = 4'hF;
    an[sel] = 1'b0;
    return {an, ~lit7(sh_diglo[sel*4 +: 4]), ~sh_ctrl[16+sel]};
  endfunction

  task automatic scan_window(input string tag, input int n);
    repeat (n) begin
      @(negedge HCLK);
      check(tag, {20'd0, AN, CA, CB, CC, CD, CE, CF, CG, DP}, {20'd0, expect_pads(s)});
    end
  endtask

  task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(negedge HCLK);
    @(negedge HCLK);
    case (a)
      4'h0: sh_diglo = d;
      4'h4: sh_dighi = d;
      4'h8: sh_ctrl  = d;
      4'hC: sh_cfg   = {12'h0, d[19:0]};
      default: ;
    endcase
  endtask

  task automatic ahb_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  task automatic wait_an(input string tag, input logic [3:0] target);
    int n;
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (AN !== target && n < 300);
    if (AN !== target) check(tag, {28'd0, AN}, {28'd0, target});
  endtask

  task automatic reset_shadow();
    sh_diglo = 32'h0; sh_dighi = 32'h0; sh_ctrl = 32'h0000_FFFF; sh_cfg = 32'h000F_0000;
  endtask

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    HADDR = 4'h0; HWDATA = 32'h0;
    reset_shadow();

    // Reset held for three cycles
    repeat (3) begin
      @(negedge HCLK);
      check("rst_an", {28'd0, AN}, 32'h0000_000F);
    end
    HRESET = 1'b0;

    // Scan order from digit 0, 16 cycles per digit
    scan_window("scan_reset", 80);

    ahb_read(4'h0, rd); check("rd_diglo", rd, 32'h0000_0000);
    ahb_read(4'h4, rd); check("rd_dighi", rd, 32'h0000_0000);
    ahb_read(4'h8, rd); check("rd_ctrl",  rd, 32'h0000_FFFF);
    ahb_read(4'hC, rd); check("rd_cfg",   rd, 32'h000F_0000);
    @(negedge HCLK);
    check("rd_idle", HRDATA, 32'h0);

    // Digit values
    ahb_write(4'h0, 32'h0000_A3C1);
    wait_an("wait_d0", 4'b1110);
    check("seg_d0_1", {25'd0, CA, CB, CC, CD, CE, CF, CG}, 32'b1001111);
    wait_an("wait_d3", 4'b0111);
    check("seg_d3_A", {25'd0, CA, CB, CC, CD, CE, CF, CG}, 32'b0001000);
    scan_window("scan_digits", 64);

    // Digit enable and decimal point
    ahb_write(4'h8, 32'h0004_0005);
    scan_window("scan_en5", 64);
    ahb_write(4'h8, 32'h0004_000F);
    scan_window("scan_dp2", 64);

    // Blink digit 1 at minimum brightness
    ahb_write(4'hC, 32'h0000_0002);
    scan_window("scan_blink", 192);

    // Write then read back-to-back
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 4'h4;
    @(negedge HCLK);
    HWRITE = 1'b0; HADDR = 4'h4; HWDATA = 32'h5E7B_9D20;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    check("b2b_dighi", HRDATA, 32'h5E7B_9D20);
    sh_dighi = 32'h5E7B_9D20;
    ahb_read(4'h3, rd); check("rd_unmapped", rd, 32'h0);

    // Reset while digit 2 is selected
    begin
      int n;
      n = 0;
      while (((s / 16) % 4) != 2 && n < 200) begin
        @(negedge HCLK);
        n++;
      end
      check("sel2_reached", ((s / 16) % 4), 2);
    end
    HRESET = 1'b1;
    @(negedge HCLK);
    check("midrst_an", {28'd0, AN}, 32'h0000_000F);
    HRESET = 1'b0;
    reset_shadow();
    scan_window("scan_restart", 40);
    ahb_read(4'h0, rd); check("rst_diglo", rd, 32'h0000_0000);
    ahb_read(4'h4, rd); check("rst_dighi", rd, 32'h0000_0000);
    ahb_read(4'h8, rd); check("rst_ctrl",  rd, 32'h0000_FFFF);
    ahb_read(4'hC, rd); check("rst_cfg",   rd, 32'h000F_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
